// File: rtl/alu8_issue_seq.sv
// Issue/writeback sequencer around an 8-bit combinational ALU: registers one op onto the
// ALU inputs, captures the result a cycle later, and holds it under a valid/ready handshake.
module alu8_issue_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [7:0]       in_op1,
  input  logic [7:0]       in_op2,
  input  logic             in_use_acc,
  output logic [3:0]       alu_opcode,
  output logic [7:0]       alu_operand1,
  output logic [7:0]       alu_operand2,
  input  logic [15:0]      alu_result,
  input  logic             alu_flagC,
  input  logic             alu_flagZ,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_flagC,
  output logic             out_flagZ,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never waits for ready, and out_* stay frozen while out_valid && !out_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [3:0] OP_DIV = 4'd3;

  state_e           state_q;
  logic [3:0]       alu_opcode_q;
  logic [7:0]       alu_operand1_q;
  logic [7:0]       alu_operand2_q;
  logic [7:0]       acc_q;
  logic             out_valid_q;
  logic [15:0]      out_result_q;
  logic             out_flagC_q;
  logic             out_flagZ_q;
  logic             out_err_q;
  logic [CNT_W-1:0] op_count_q;

  logic       accept;
  logic       consume;
  logic [7:0] operand1_d;
  logic       exec_err;

  always_comb begin
    in_ready   = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    accept     = in_valid & in_ready;
    consume    = out_valid_q & out_ready;
    operand1_d = in_use_acc ? acc_q : in_op1;
    // Screened ops never trust the ALU output; opcodes above XOR are undefined.
    exec_err   = (alu_opcode_q > 4'd8) | ((alu_opcode_q == OP_DIV) & (alu_operand2_q == 8'd0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      alu_opcode_q   <= '0;
      alu_operand1_q <= '0;
      alu_operand2_q <= '0;
      acc_q          <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_flagC_q    <= 1'b0;
      out_flagZ_q    <= 1'b0;
      out_err_q      <= 1'b0;
      op_count_q     <= '0;
    end else begin
      if (consume) begin
        out_valid_q <= 1'b0;
        op_count_q  <= op_count_q + CNT_W'(1);
      end
      if (accept) begin
        alu_opcode_q   <= in_opcode;
        alu_operand1_q <= operand1_d;
        alu_operand2_q <= in_op2;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= EXEC;
        end
        EXEC: begin
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
          if (exec_err) begin
            out_result_q <= '0;
            out_flagC_q  <= 1'b0;
            out_flagZ_q  <= 1'b0;
            out_err_q    <= 1'b1;
          end else begin
            out_result_q <= alu_result;
            out_flagC_q  <= (alu_opcode_q <= 4'd1) ? alu_flagC : 1'b0;
            out_flagZ_q  <= alu_flagZ;
            out_err_q    <= 1'b0;
            acc_q        <= alu_result[7:0];
          end
        end
        HOLD: begin
          if (out_ready) state_q <= in_valid ? EXEC : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_opcode   = alu_opcode_q;
  assign alu_operand1 = alu_operand1_q;
  assign alu_operand2 = alu_operand2_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_flagC    = out_flagC_q;
  assign out_flagZ    = out_flagZ_q;
  assign out_err      = out_err_q;
  assign op_count     = op_count_q;
  assign dbg_state_o  = state_q;

endmodule
